// File: rtl/mmio_timer_pkg.sv
// Shared register map and CTRL/STATUS field layout for the memory-mapped timer.
package mmio_timer_pkg;

    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_COUNT  = 3'd1;
    localparam logic [2:0] TMR_CMP    = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;
    localparam logic [2:0] TMR_PRESC  = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_FLAG = 0;

    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer_if.sv
// Processor data-bus view of the timer window: store strobe, address, data both ways.
interface mmio_timer_if;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Irq;

    modport master (output MemWrite, Adr, WriteData, input ReadData, Hit, Irq);
    modport slave  (input MemWrite, Adr, WriteData, output ReadData, Hit, Irq);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescale counter: PCNT runs 0..presc while enabled and tick marks the terminal cycle.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] pcnt_r;

    assign tick = en && (pcnt_r == presc);

    // PCNT advances while enabled, restarting after each tick or on any reconfiguration
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_r <= 16'd0;
        end else if (clr || !en || tick) begin
            pcnt_r <= 16'd0;
        end else begin
            pcnt_r <= pcnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Timer peripheral on the processor data bus: 8-word window with prescaled counter and compare.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_0100
) (
    input logic         clk,
    input logic         reset,
    mmio_timer_if.slave bus
);

    ctrl_t       ctrl_r;
    logic [31:0] count_r;
    logic [31:0] cmp_r;
    logic        flag_r;
    logic [15:0] presc_r;

    logic        hit_s;
    logic        wr_s;
    logic [2:0]  off_s;
    logic        tick_s;
    logic        match_s;
    logic        pclr_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign hit_s    = (bus.Adr[31:5] == BASE[31:5]);
    assign off_s    = bus.Adr[4:2];
    assign wr_s     = bus.MemWrite && hit_s;
    assign match_s  = (count_r == cmp_r);
    assign pclr_s   = wr_s && ((off_s == TMR_CTRL) || (off_s == TMR_PRESC));
    assign unused_s = ^bus.Adr[1:0];

    timer_prescaler u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_r.en),
        .clr   (pclr_s),
        .presc (presc_r),
        .tick  (tick_s)
    );

    // Register file; software COUNT writes beat ticks, match set beats W1C clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r  <= '0;
            count_r <= 32'd0;
            cmp_r   <= 32'd0;
            flag_r  <= 1'b0;
            presc_r <= 16'd0;
        end else begin
            if (wr_s && (off_s == TMR_CTRL)) begin
                ctrl_r <= '{ie: bus.WriteData[CTRL_IE], ar: bus.WriteData[CTRL_AR],
                            en: bus.WriteData[CTRL_EN]};
            end
            if (wr_s && (off_s == TMR_CMP)) begin
                cmp_r <= bus.WriteData;
            end
            if (wr_s && (off_s == TMR_PRESC)) begin
                presc_r <= bus.WriteData[15:0];
            end
            if (wr_s && (off_s == TMR_COUNT)) begin
                count_r <= bus.WriteData;
            end else if (tick_s) begin
                count_r <= (match_s && ctrl_r.ar) ? 32'd0 : count_r + 32'd1;
            end
            if (tick_s && match_s) begin
                flag_r <= 1'b1;
            end else if (wr_s && (off_s == TMR_STATUS) && bus.WriteData[STAT_FLAG]) begin
                flag_r <= 1'b0;
            end
        end
    end

    // Zero-latency read mux; anything outside the window reads 0 so top can OR/mux freely
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            case (off_s)
                TMR_CTRL:   rdata_s = {29'd0, ctrl_r};
                TMR_COUNT:  rdata_s = count_r;
                TMR_CMP:    rdata_s = cmp_r;
                TMR_STATUS: rdata_s = {31'd0, flag_r};
                TMR_PRESC:  rdata_s = {16'd0, presc_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.ReadData = rdata_s;
    assign bus.Hit      = hit_s;
    assign bus.Irq      = flag_r && ctrl_r.ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with a cycle-level reference model and literal spot checks.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk;
    logic reset;
    mmio_timer_if bus ();

    mmio_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // Reference state: register contents plus cycles remaining until the next tick
    bit [2:0]  m_ctrl;
    bit [31:0] m_count;
    bit [31:0] m_cmp;
    bit        m_flag;
    bit [15:0] m_presc;
    int        m_wait;

    function automatic bit m_hit(input logic [31:0] adr);
        return adr[31:5] == BASE[31:5];
    endfunction

    function automatic bit [31:0] m_rdata(input logic [31:0] adr);
        if (!m_hit(adr)) return 32'd0;
        case (adr[4:2])
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return m_count;
            3'd2:    return m_cmp;
            3'd3:    return {31'd0, m_flag};
            3'd4:    return {16'd0, m_presc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                              input logic rst);
        bit wr;
        bit tick;
        bit match;
        int off;
        wr    = we && m_hit(adr);
        off   = int'(adr[4:2]);
        tick  = m_ctrl[0] && (m_wait == 0);
        match = (m_count == m_cmp);
        if (rst) begin
            m_ctrl = 3'd0; m_count = 32'd0; m_cmp = 32'd0; m_flag = 1'b0;
            m_presc = 16'd0; m_wait = 0;
            return;
        end
        if (wr && off == 1) m_count = wd;
        else if (tick) m_count = (match && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        if (tick && match) m_flag = 1'b1;
        else if (wr && off == 3 && wd[0]) m_flag = 1'b0;
        if (wr && off == 0) m_ctrl = wd[2:0];
        if (wr && off == 2) m_cmp = wd;
        if (wr && off == 4) m_presc = wd[15:0];
        if (wr && (off == 0 || off == 4)) m_wait = int'(m_presc);
        else if (!m_ctrl[0] || tick) m_wait = int'(m_presc);
        else m_wait = m_wait - 1;
    endtask

    // Every-cycle comparison of all bus outputs against the reference model
    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (bus.ReadData !== m_rdata(bus.Adr)) begin
                miscompares++;
                $display("FAIL model_rdata t=%0t adr=%h: got %h want %h", $time, bus.Adr,
                         bus.ReadData, m_rdata(bus.Adr));
            end
            vectors++;
            if (bus.Hit !== m_hit(bus.Adr)) begin
                miscompares++;
                $display("FAIL model_hit t=%0t adr=%h: got %b want %b", $time, bus.Adr,
                         bus.Hit, m_hit(bus.Adr));
            end
            vectors++;
            if (bus.Irq !== (m_flag & m_ctrl[2])) begin
                miscompares++;
                $display("FAIL model_irq t=%0t: got %b want %b", $time, bus.Irq,
                         m_flag & m_ctrl[2]);
            end
        end
    end

    task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rst, input bit chk_rd, input logic [31:0] exp_rd,
                       input bit chk_irq, input logic exp_irq, input string name);
        bus.MemWrite  = we;
        bus.Adr       = adr;
        bus.WriteData = wd;
        reset         = rst;
        @(negedge clk);
        if (chk_rd) begin
            vectors++;
            if (bus.ReadData !== exp_rd) begin
                miscompares++;
                $display("FAIL %s: ReadData=%h expected %h", name, bus.ReadData, exp_rd);
            end
        end
        if (chk_irq) begin
            vectors++;
            if (bus.Irq !== exp_irq) begin
                miscompares++;
                $display("FAIL %s: Irq=%b expected %b", name, bus.Irq, exp_irq);
            end
        end
        @(posedge clk);
        model_edge(we, adr, wd, rst);
        #1;
    endtask

    function automatic logic [31:0] wa(input int off);
        return BASE + 32'(off * 4);
    endfunction

    task automatic wr(input int off, input logic [31:0] d);
        cyc(1'b1, wa(off), d, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "");
    endtask

    task automatic rd(input int off, input logic [31:0] e, input string name);
        cyc(1'b0, wa(off), 32'd0, 1'b0, 1'b1, e, 1'b0, 1'b0, name);
    endtask

    task automatic hit_expect(input logic [31:0] adr, input logic e);
        bus.MemWrite = 1'b0;
        bus.Adr      = adr;
        @(negedge clk);
        vectors++;
        if (bus.Hit !== e) begin
            miscompares++;
            $display("FAIL hit_%h: Hit=%b expected %b", adr, bus.Hit, e);
        end
        @(posedge clk);
        model_edge(1'b0, adr, 32'd0, 1'b0);
        #1;
    endtask

    logic [31:0] seq2 [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1, 32'd2};
    logic [31:0] seq3 [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    logic [31:0] seq4 [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};

    initial begin
        bus.MemWrite = 1'b0; bus.Adr = 32'd0; bus.WriteData = 32'd0; reset = 1'b1;
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "");
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "");
        chk_on = 1'b1;

        // Reset state and address window
        for (int i = 0; i < 8; i++) cyc(1'b0, wa(i), 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0,
                                        "reset_read");
        for (int i = 0; i < 8; i++) hit_expect(wa(i), 1'b1);
        hit_expect(32'h0000_00FC, 1'b0);
        hit_expect(32'h0000_0120, 1'b0);
        cyc(1'b0, 32'h0000_0120, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, "miss_read");

        // Auto-reload, PRESC=0, CMP=5
        wr(4, 32'd0); wr(2, 32'd5); wr(0, 32'd3);
        for (int i = 0; i < 9; i++) rd(1, seq2[i], "ar_count");
        cyc(1'b0, wa(3), 32'd0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0, "ar_flag_no_irq");

        // Prescaled counting, PRESC=3
        wr(0, 32'd0); wr(1, 32'd0); wr(3, 32'd1); wr(4, 32'd3); wr(0, 32'd1);
        for (int i = 0; i < 9; i++) rd(1, seq3[i], "presc_count");

        // Wrap through 2^32 without a match
        wr(0, 32'd0); wr(1, 32'hFFFF_FFFE); wr(2, 32'd7); wr(4, 32'd0); wr(0, 32'd1);
        for (int i = 0; i < 4; i++) rd(1, seq4[i], "wrap_count");
        rd(3, 32'd0, "wrap_flag");

        // Interrupt, match-vs-W1C priority, then a clean clear
        wr(0, 32'd0); wr(1, 32'd0);
        cyc(1'b1, BASE + 32'h0000_000B, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "");
        wr(4, 32'd0); wr(3, 32'd1); wr(0, 32'd7);
        rd(1, 32'd0, "irq_c0"); rd(1, 32'd1, "irq_c1");
        cyc(1'b0, wa(1), 32'd0, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, "irq_before_match");
        cyc(1'b0, wa(1), 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1, "irq_raised");
        rd(1, 32'd1, "irq_c1b");
        cyc(1'b1, wa(3), 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, "w1c_on_match");
        cyc(1'b0, wa(3), 32'd0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1, "flag_kept");
        wr(3, 32'd1);
        cyc(1'b0, wa(3), 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, "w1c_cleared");
        rd(3, 32'd1, "flag_reset_by_match");

        // Reset mid-count with Irq active
        wr(0, 32'd4); wr(1, 32'd0); wr(2, 32'd100); wr(0, 32'd5);
        rd(1, 32'd0, "pre_rst0"); rd(1, 32'd1, "pre_rst1"); rd(1, 32'd2, "pre_rst2");
        cyc(1'b0, wa(1), 32'd0, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1, "pre_rst3");
        for (int i = 0; i < 8; i++) cyc(1'b0, wa(i), 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0,
                                        "post_reset");
        wr(6, 32'hDEAD_BEEF);
        rd(6, 32'd0, "unmapped_write");
        rd(1, 32'd0, "count_idle");

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral on the multicycle RISC-V processor's data bus, next to the instruction/data RAM. It decodes the processor's `Adr`/`MemWrite`/`WriteData` outputs and returns `ReadData` for its own address window. Inside that window it implements a prescaled 32-bit up-counter with a compare register, a sticky match flag and an interrupt output. `top` muxes its `ReadData` against the RAM's `rd` using `Hit`.

## Interface
- `BASE`, default 32'h0000_0100: window base; must be 32-byte aligned; the window is 8 words.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `MemWrite`  in  1: processor store strobe.
- `Adr`  in  32: processor byte address; only word accesses.
- `WriteData`  in  32: store data.
- `ReadData`  out  32: combinational read data; 0 when `Hit`=0.
- `Hit`  out  1: `Adr[31:5]==BASE[31:5]`, combinational.
- `Irq`  out  1: `FLAG & CTRL.IE`, from registers only.

## Operation
- Register map, word offset `Adr[4:2]`:
  - 0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
  - 1 COUNT: R/W.
  - 2 CMP: R/W.
  - 3 STATUS: bit0 FLAG, read; writing 1 to bit0 clears it.
  - 4 PRESC: R/W, 16 bits; upper bits read 0.
  - 5–7: read 0; writes ignored.
- Write: `MemWrite & Hit` at a rising edge updates the addressed register. `Adr[1:0]` is ignored.
- Prescaler: internal 16-bit PCNT.
  - When EN=1, PCNT counts 0..PRESC. TICK is asserted in the cycle PCNT==PRESC, and PCNT then returns to 0.
  - PRESC=0 gives TICK every cycle.
  - EN=0 holds PCNT at 0.
  - Any write to PRESC or CTRL zeroes PCNT.
- On TICK:
  - If COUNT==CMP: FLAG←1, and COUNT←0 when AR=1, else COUNT←COUNT+1.
  - Otherwise COUNT←COUNT+1.
  - Increment is modulo 2^32; 32'hFFFF_FFFF wraps to 0 with no flag unless CMP matches.
- Priorities in the same cycle:
  - A software write to COUNT beats the tick update; the written value is loaded.
  - A set of FLAG from a match beats a W1C clear; FLAG stays 1.
  - A CMP write in the same cycle as a tick: the compare uses the old CMP.
- Reset: CTRL, COUNT, CMP, STATUS, PRESC and PCNT all go to 0. `Irq`=0 from the first edge with reset high. Reset mid-count discards all state.

## Timing
- Reads are combinational, with zero-cycle latency: `ReadData` reflects register state in the same cycle `Adr` is presented. This matches the processor's single-ported RAM read timing.
- Writes are visible on `ReadData` in the cycle after the edge.
- With EN set at edge N and PRESC=P:
  - The first TICK occurs in cycle N+P+1 (the cycle PCNT==P).
  - COUNT changes at the end of that cycle.
  - COUNT ticks every P+1 cycles.
- FLAG and `Irq` rise one edge after the matching TICK cycle. `Irq` falls one edge after the W1C write or the IE clear.
- No handshake: accesses complete in one cycle and the block never stalls the processor.

## Structure
- Package `mmio_timer_pkg` holds:
  - the register offset constants (`TMR_CTRL`=3'd0 … `TMR_PRESC`=3'd4);
  - CTRL bit indices (`CTRL_EN`, `CTRL_AR`, `CTRL_IE`);
  - `STAT_FLAG`.
- Sub-module `timer_prescaler` holds PCNT and TICK generation, with ports `clk`, `reset`, `en`, `clr`, `presc[15:0]`, `tick`.
- Top level holds:
  - the address decode;
  - the register flops (behavioural `always_ff`);
  - the combinational read mux.

## Test plan
- Reset, then read offsets 0–7 → all 0; `Irq`=0, `Hit`=1 for 0x100–0x11C, `Hit`=0 for 0x0FC and 0x120.
- Write PRESC=0, CMP=5, CTRL=3'b011 (EN+AR) → COUNT sequence 0,1,2,3,4,5,0,1…; FLAG set at the edge after COUNT==5; `Irq` stays 0 (IE=0).
- Write PRESC=3, CTRL=1 → COUNT increments every 4 cycles; first increment 4 cycles after the CTRL write edge.
- Write COUNT=32'hFFFF_FFFE, CMP=7, PRESC=0, CTRL=1 → COUNT reads FFFF_FFFF, then 0, then 1; FLAG remains 0.
- Set IE with FLAG=1 → `Irq`=1. Write STATUS=1 in the same cycle a new match ticks → FLAG stays 1. Write STATUS=1 with no match → `Irq`=0 next cycle.
- Assert reset for 1 cycle mid-count (COUNT=3) → all registers read 0 and `Irq`=0. A write to offset 6 with 32'hDEAD_BEEF reads back 0.
